// File: rtl/vx_tma_addr_gen.sv
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
`ifndef NUM_CORES
`define NUM_CORES 1
`endif
`ifndef NUM_WARPS
`define NUM_WARPS 4
`endif
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif
`ifndef UP
`define UP(x) (((x) > 0) ? (x) : 1)
`endif

// ============================================================================
// Module      : vx_tma_addr_gen
// Description : Tensor-memory-access address generator. Accepts one 2-D tile
//               descriptor, then walks the tile (x inner, y outer) and emits
//               one request per element carrying the global byte address, the
//               densely packed shared-memory address, an out-of-bounds flag
//               and a last marker. A one-cycle done pulse closes each transfer.
// Ports       : clk, reset (async, active high)
//               in_*   : descriptor handshake and fields
//               req_*  : per-element request handshake and payload
//               done_* : end-of-transfer pulse and its context tag
//               busy   : high whenever the walker is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module vx_tma_addr_gen #(
  parameter int TMA_CTX_BITS = `UP(`CLOG2(`NUM_CORES * `NUM_WARPS)),
  parameter int TILE_W       = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [TMA_CTX_BITS-1:0]     in_tag,
  input  logic [`MEM_ADDR_WIDTH-1:0]  in_base_addr,
  input  logic [`XLEN-1:0]            in_smem_addr,
  input  logic [`XLEN-1:0]            in_coord0,
  input  logic [`XLEN-1:0]            in_coord1,
  input  logic [31:0]                 in_tile01,
  input  logic [31:0]                 in_size0,
  input  logic [31:0]                 in_size1,
  input  logic [31:0]                 in_stride0,
  input  logic [1:0]                  in_elem_log2,
  output logic                        req_valid,
  input  logic                        req_ready,
  output logic [`MEM_ADDR_WIDTH-1:0]  req_addr,
  output logic [`XLEN-1:0]            req_smem_addr,
  output logic                        req_oob,
  output logic                        req_last,
  output logic [TMA_CTX_BITS-1:0]     req_tag,
  output logic                        done_valid,
  output logic [TMA_CTX_BITS-1:0]     done_tag,
  output logic                        busy
);

  localparam int c_aw = `MEM_ADDR_WIDTH;
  localparam int c_xl = `XLEN;
  localparam int c_cw = `XLEN + 1;  // signed bounds-check width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t                   r_state;
  logic [TMA_CTX_BITS-1:0]  r_tag;
  logic [c_aw-1:0]          r_base;
  logic signed [c_xl-1:0]   r_coord0;
  logic signed [c_xl-1:0]   r_coord1;
  logic [TILE_W-1:0]        r_tile0;
  logic [TILE_W-1:0]        r_tile1;
  logic [31:0]              r_size0;
  logic [31:0]              r_size1;
  logic [31:0]              r_stride0;
  logic [1:0]               r_elem_log2;
  logic [c_aw-1:0]          r_row_addr;
  logic [c_aw-1:0]          r_col_addr;
  logic [c_xl-1:0]          r_smem_ptr;
  logic [TILE_W-1:0]        r_x_cnt;
  logic [TILE_W-1:0]        r_y_cnt;
  // Completion is staged one cycle before done_valid; the tag is kept apart
  // from r_tag so a descriptor accepted meanwhile cannot overwrite it.
  logic                     r_fin_pend;
  logic [TMA_CTX_BITS-1:0]  r_fin_tag;
  logic                     r_done_valid;
  logic [TMA_CTX_BITS-1:0]  r_done_tag;

  logic [c_aw-1:0]          w_origin;
  logic [c_aw-1:0]          w_addr_step;
  logic [c_xl-1:0]          w_smem_step;
  logic signed [c_cw-1:0]   w_cx;
  logic signed [c_cw-1:0]   w_cy;
  logic signed [c_cw-1:0]   w_sx;
  logic signed [c_cw-1:0]   w_sy;
  logic                     w_x_end;
  logic                     w_y_end;
  logic                     w_last;
  logic                     w_fire;

  // Element (0,0) address; signed coordinates are sign-extended so negative
  // origins wrap correctly modulo the address width.
  assign w_origin    = r_base
                     + c_aw'(r_coord1) * c_aw'(r_stride0)
                     + (c_aw'(r_coord0) << r_elem_log2);
  assign w_addr_step = c_aw'(1) << r_elem_log2;
  assign w_smem_step = c_xl'(1) << r_elem_log2;

  assign w_cx = c_cw'(r_coord0) + c_cw'({1'b0, r_x_cnt});
  assign w_cy = c_cw'(r_coord1) + c_cw'({1'b0, r_y_cnt});
  assign w_sx = c_cw'({1'b0, r_size0});
  assign w_sy = c_cw'({1'b0, r_size1});

  assign w_x_end = (r_x_cnt == r_tile0 - TILE_W'(1));
  assign w_y_end = (r_y_cnt == r_tile1 - TILE_W'(1));
  assign w_last  = w_x_end & w_y_end;
  assign w_fire  = (r_state == ST_RUN) & req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_tag        <= '0;
      r_base       <= '0;
      r_coord0     <= '0;
      r_coord1     <= '0;
      r_tile0      <= '0;
      r_tile1      <= '0;
      r_size0      <= '0;
      r_size1      <= '0;
      r_stride0    <= '0;
      r_elem_log2  <= '0;
      r_row_addr   <= '0;
      r_col_addr   <= '0;
      r_smem_ptr   <= '0;
      r_x_cnt      <= '0;
      r_y_cnt      <= '0;
      r_fin_pend   <= 1'b0;
      r_fin_tag    <= '0;
      r_done_valid <= 1'b0;
      r_done_tag   <= '0;
    end else begin
      r_done_valid <= r_fin_pend;
      if (r_fin_pend) begin
        r_done_tag <= r_fin_tag;
      end
      r_fin_pend <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_tag       <= in_tag;
            r_base      <= in_base_addr;
            r_smem_ptr  <= in_smem_addr;
            r_coord0    <= in_coord0;
            r_coord1    <= in_coord1;
            r_tile0     <= in_tile01[TILE_W-1:0];
            r_tile1     <= in_tile01[2*TILE_W-1:TILE_W];
            r_size0     <= in_size0;
            r_size1     <= in_size1;
            r_stride0   <= in_stride0;
            r_elem_log2 <= in_elem_log2;
            r_x_cnt     <= '0;
            r_y_cnt     <= '0;
            r_state     <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          r_row_addr <= w_origin;
          r_col_addr <= w_origin;
          if ((r_tile0 == '0) || (r_tile1 == '0)) begin
            // Empty tile: finish without emitting any request.
            r_fin_pend <= 1'b1;
            r_fin_tag  <= r_tag;
            r_state    <= ST_IDLE;
          end else begin
            r_state <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (w_fire) begin
            r_smem_ptr <= r_smem_ptr + w_smem_step;
            if (!w_x_end) begin
              r_x_cnt    <= r_x_cnt + TILE_W'(1);
              r_col_addr <= r_col_addr + w_addr_step;
            end else begin
              // Next row starts one pitch below the current row start.
              r_x_cnt    <= '0;
              r_y_cnt    <= r_y_cnt + TILE_W'(1);
              r_row_addr <= r_row_addr + c_aw'(r_stride0);
              r_col_addr <= r_row_addr + c_aw'(r_stride0);
            end
            if (w_last) begin
              r_fin_pend <= 1'b1;
              r_fin_tag  <= r_tag;
              r_state    <= ST_IDLE;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready      = (r_state == ST_IDLE);
  assign busy          = (r_state != ST_IDLE);
  assign req_valid     = (r_state == ST_RUN);
  assign req_addr      = r_col_addr;
  assign req_smem_addr = r_smem_ptr;
  assign req_tag       = r_tag;
  assign req_last      = w_last;
  // Bounds test on the signed element coordinate; negative shows as sign bit.
  assign req_oob       = w_cx[c_cw-1] | (w_cx >= w_sx) |
                         w_cy[c_cw-1] | (w_cy >= w_sy);
  assign done_valid    = r_done_valid;
  assign done_tag      = r_done_tag;

endmodule

`default_nettype wire

// File: tb/tb_vx_tma_addr_gen.sv
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif

// ============================================================================
// Module      : tb_vx_tma_addr_gen
// Description : Directed self-checking bench for vx_tma_addr_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vx_tma_addr_gen;

  localparam int TAG_W = 2;

  logic                       clk;
  logic                       reset;
  logic                       in_valid;
  logic                       in_ready;
  logic [TAG_W-1:0]           in_tag;
  logic [`MEM_ADDR_WIDTH-1:0] in_base_addr;
  logic [`XLEN-1:0]           in_smem_addr;
  logic [`XLEN-1:0]           in_coord0;
  logic [`XLEN-1:0]           in_coord1;
  logic [31:0]                in_tile01;
  logic [31:0]                in_size0;
  logic [31:0]                in_size1;
  logic [31:0]                in_stride0;
  logic [1:0]                 in_elem_log2;
  logic                       req_valid;
  logic                       req_ready;
  logic [`MEM_ADDR_WIDTH-1:0] req_addr;
  logic [`XLEN-1:0]           req_smem_addr;
  logic                       req_oob;
  logic                       req_last;
  logic [TAG_W-1:0]           req_tag;
  logic                       done_valid;
  logic [TAG_W-1:0]           done_tag;
  logic                       busy;

  int total;
  int bad;
  int fires;

  vx_tma_addr_gen #(
    .TMA_CTX_BITS (TAG_W),
    .TILE_W       (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_tag        (in_tag),
    .in_base_addr  (in_base_addr),
    .in_smem_addr  (in_smem_addr),
    .in_coord0     (in_coord0),
    .in_coord1     (in_coord1),
    .in_tile01     (in_tile01),
    .in_size0      (in_size0),
    .in_size1      (in_size1),
    .in_stride0    (in_stride0),
    .in_elem_log2  (in_elem_log2),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_smem_addr (req_smem_addr),
    .req_oob       (req_oob),
    .req_last      (req_last),
    .req_tag       (req_tag),
    .done_valid    (done_valid),
    .done_tag      (done_tag),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input logic [TAG_W-1:0] tag, input logic [31:0] base,
                          input logic [31:0] smem, input logic [31:0] c0,
                          input logic [31:0] c1, input logic [31:0] tile01,
                          input logic [31:0] s0, input logic [31:0] s1,
                          input logic [31:0] stride, input logic [1:0] elog);
    in_tag       = tag;
    in_base_addr = base;
    in_smem_addr = smem;
    in_coord0    = c0;
    in_coord1    = c1;
    in_tile01    = tile01;
    in_size0     = s0;
    in_size1     = s1;
    in_stride0   = stride;
    in_elem_log2 = elog;
  endtask

  // 2x2 tile, 4-byte elements, pitch 32, base 0x1000, smem 0x200.
  task automatic run_basic(input logic [TAG_W-1:0] tag);
    logic [31:0] ea [4];
    logic [31:0] es [4];
    ea = '{32'h1000, 32'h1004, 32'h1020, 32'h1024};
    es = '{32'h200, 32'h204, 32'h208, 32'h20C};
    req_ready = 1'b1;
    set_desc(tag, 32'h1000, 32'h200, 32'd0, 32'd0, 32'h0002_0002, 32'd8, 32'd8, 32'd32, 2'd2);
    in_valid = 1'b1;
    check("basic_in_ready", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    check("basic_setup_busy", busy, 1);
    check("basic_setup_noreq", req_valid, 0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      check("basic_req_valid", req_valid, 1);
      check("basic_req_addr", req_addr, ea[i]);
      check("basic_req_smem", req_smem_addr, es[i]);
      check("basic_req_oob", req_oob, 0);
      check("basic_req_last", req_last, (i == 3) ? 1 : 0);
      check("basic_req_tag", req_tag, tag);
      cyc();
    end
    check("basic_idle_noreq", req_valid, 0);
    check("basic_idle_nodone", done_valid, 0);
    check("basic_idle_ready", in_ready, 1);
    cyc();
    check("basic_done_valid", done_valid, 1);
    check("basic_done_tag", done_tag, tag);
    check("basic_done_ready", in_ready, 1);
    cyc();
    check("basic_done_pulse", done_valid, 0);
  endtask

  initial begin
    logic [3:0] exp_oob;
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    req_ready = 1'b1;
    set_desc('0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0);

    // Reset state
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_req_valid", req_valid, 0);
    check("rst_done_valid", done_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_req_addr", req_addr, 0);
    check("rst_req_smem", req_smem_addr, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("post_rst_ready", in_ready, 1);
    check("post_rst_busy", busy, 0);

    // Basic 2x2 transfer
    run_basic(2'd1);

    // Out-of-bounds pattern: coords (-1,7), tile 2x2, size 8x8
    exp_oob = 4'b1101;  // bit i = request i
    set_desc(2'd2, 32'h2000, 32'h0, 32'hFFFF_FFFF, 32'd7, 32'h0002_0002, 32'd8, 32'd8, 32'd32, 2'd2);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      check("oob_req_valid", req_valid, 1);
      check("oob_flag", req_oob, exp_oob[i]);
      check("oob_smem", req_smem_addr, 32'(i * 4));
      if (i == 1) check("oob_inbound_addr", req_addr, 32'h20E0);
      cyc();
    end
    cyc();
    check("oob_done_tag", done_tag, 2'd2);
    check("oob_done_valid", done_valid, 1);
    cyc();

    // Empty tile: tile0 = 0
    set_desc(2'd3, 32'h1000, 32'h0, 32'd0, 32'd0, 32'h0003_0000, 32'd8, 32'd8, 32'd32, 2'd2);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    check("empty_c1_noreq", req_valid, 0);
    check("empty_c1_nodone", done_valid, 0);
    cyc();
    check("empty_c2_noreq", req_valid, 0);
    check("empty_c2_nodone", done_valid, 0);
    cyc();
    check("empty_c3_noreq", req_valid, 0);
    check("empty_c3_done", done_valid, 1);
    check("empty_c3_tag", done_tag, 2'd3);
    cyc();
    check("empty_c4_nodone", done_valid, 0);

    // Backpressure: 2x1 tile, 2-byte elements, ready pattern 1,0,0,1
    fires = 0;
    set_desc(2'd0, 32'h3000, 32'h100, 32'd1, 32'd2, 32'h0001_0002, 32'd8, 32'd8, 32'd64, 2'd1);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    req_ready = 1'b1;
    check("bp_r0_addr", req_addr, 32'h3082);
    check("bp_r0_smem", req_smem_addr, 32'h100);
    check("bp_r0_last", req_last, 0);
    if (req_valid && req_ready) fires++;
    cyc();
    for (int k = 0; k < 3; k++) begin
      req_ready = (k == 2);
      check("bp_r1_valid", req_valid, 1);
      check("bp_r1_addr", req_addr, 32'h3084);
      check("bp_r1_smem", req_smem_addr, 32'h102);
      check("bp_r1_last", req_last, 1);
      check("bp_r1_oob", req_oob, 0);
      if (req_valid && req_ready) fires++;
      cyc();
    end
    req_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (req_valid && req_ready) fires++;
      cyc();
    end
    check("bp_fire_count", fires, 2);
    cyc();

    // Reset mid-transfer after the first of four requests
    set_desc(2'd2, 32'h1000, 32'h200, 32'd0, 32'd0, 32'h0002_0002, 32'd8, 32'd8, 32'd32, 2'd2);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    check("mid_r0_addr", req_addr, 32'h1000);
    cyc();
    check("mid_r1_addr", req_addr, 32'h1004);
    #2;
    reset = 1'b1;
    #1;
    check("mid_async_noreq", req_valid, 0);
    check("mid_async_busy", busy, 0);
    check("mid_async_ready", in_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("mid_no_done", done_valid, 0);
      check("mid_no_req", req_valid, 0);
      cyc();
    end
    run_basic(2'd3);

    // Back-to-back: second descriptor presented in the done cycle
    set_desc(2'd1, 32'h4000, 32'h0, 32'd0, 32'd0, 32'h0001_0001, 32'd8, 32'd8, 32'd64, 2'd3);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    check("b2b_a_addr", req_addr, 32'h4000);
    check("b2b_a_last", req_last, 1);
    cyc();
    check("b2b_a_idle_nodone", done_valid, 0);
    cyc();
    set_desc(2'd2, 32'h5000, 32'h40, 32'd2, 32'd0, 32'h0001_0002, 32'd8, 32'd8, 32'd64, 2'd3);
    in_valid = 1'b1;
    check("b2b_done_valid", done_valid, 1);
    check("b2b_done_ready", in_ready, 1);
    check("b2b_done_tag", done_tag, 2'd1);
    cyc();
    in_valid = 1'b0;
    check("b2b_accepted_busy", busy, 1);
    check("b2b_done_tag_hold", done_tag, 2'd1);
    check("b2b_done_pulse", done_valid, 0);
    cyc();
    check("b2b_b0_valid", req_valid, 1);
    check("b2b_b0_addr", req_addr, 32'h5010);
    check("b2b_b0_smem", req_smem_addr, 32'h40);
    check("b2b_b0_tag", req_tag, 2'd2);
    cyc();
    check("b2b_b1_addr", req_addr, 32'h5018);
    check("b2b_b1_smem", req_smem_addr, 32'h48);
    check("b2b_b1_last", req_last, 1);
    cyc();
    check("b2b_b_idle", req_valid, 0);
    cyc();
    check("b2b_b_done", done_valid, 1);
    check("b2b_b_done_tag", done_tag, 2'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vx_tma_addr_gen.md
VX_TMA_ADDR_GEN -- requirements
Module: VX_tma_addr_gen

Interface
REQ-001 Parameter TMA_CTX_BITS, default `UP(`CLOG2(`NUM_CORES * `NUM_WARPS)), width of the per-transfer context tag.
REQ-002 Parameter TILE_W, default 16, width of each tile-extent field.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid / in_ready  input / output  1 / 1  issue-descriptor handshake; transfer on in_valid && in_ready.
REQ-006 in_tag  input  TMA_CTX_BITS  context index, carried to every request and to done.
REQ-007 in_base_addr  input  `MEM_ADDR_WIDTH  global tensor byte base address.
REQ-008 in_smem_addr  input  `XLEN  shared-memory destination byte address of element (0,0).
REQ-009 in_coord0, in_coord1  input  `XLEN each  signed tile origin, x and y, in elements.
REQ-010 in_tile01  input  32  tile0 = [TILE_W-1:0] (x extent), tile1 = [2*TILE_W-1:TILE_W] (y extent).
REQ-011 in_size0, in_size1  input  32 each  unsigned tensor extents x, y, in elements.
REQ-012 in_stride0  input  32  row pitch in bytes.
REQ-013 in_elem_log2  input  2  log2 of element size in bytes (1/2/4/8 B).
REQ-014 req_valid / req_ready  output / input  1 / 1  per-element request handshake.
REQ-015 req_addr  output  `MEM_ADDR_WIDTH; req_smem_addr  output  `XLEN; req_oob  output  1; req_last  output  1; req_tag  output  TMA_CTX_BITS.
REQ-016 done_valid  output  1  one-cycle pulse at end of a transfer; done_tag  output  TMA_CTX_BITS.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, SETUP, RUN; in_ready = (state == IDLE).
REQ-019 IDLE + input fire -> SETUP; latch all inputs; x_cnt = 0, y_cnt = 0.
REQ-020 SETUP, one cycle: row_addr = base + sext(coord1)*stride0 + (sext(coord0) << elem_log2), modulo 2^`MEM_ADDR_WIDTH; col_addr = row_addr; smem_ptr = smem_addr.
REQ-021 SETUP with tile0 == 0 or tile1 == 0 -> IDLE; pulse done_valid the next cycle; emit no requests.
REQ-022 Otherwise SETUP -> RUN; first req_valid asserts 2 cycles after input fire.
REQ-023 RUN: req_valid = 1; req_addr = col_addr; req_smem_addr = smem_ptr; req_tag = latched tag.
REQ-024 While req_valid && !req_ready, all req_* outputs SHALL hold stable.
REQ-025 On req fire: smem_ptr += 1 << elem_log2; if x_cnt < tile0-1 then x_cnt++, col_addr += 1 << elem_log2; else x_cnt = 0, y_cnt++, row_addr += stride0, col_addr = row_addr + stride0.
REQ-026 Order is x inner, y outer; total request count = tile0*tile1; smem_ptr is densely packed.
REQ-027 req_oob = 1 iff (coord0 + x_cnt) < 0, or >= size0, or (coord1 + y_cnt) < 0, or >= size1, evaluated signed at `XLEN+1 bits; OOB elements are still emitted; req_addr is don't-care when req_oob = 1.
REQ-028 req_last = 1 iff x_cnt == tile0-1 && y_cnt == tile1-1.
REQ-029 Fire of the last request -> IDLE; done_valid = 1 with done_tag for exactly the following cycle, in which in_ready = 1.
REQ-030 A new input accepted in the done_valid cycle SHALL NOT corrupt done_tag of the finished transfer.
REQ-031 All address arithmetic wraps silently; no overflow detection.

Reset
REQ-032 Asynchronous reset -> IDLE; req_valid = 0, done_valid = 0, busy = 0, in_ready = 1 during and after reset; counters and pointers 0.
REQ-033 Reset mid-transfer drops the transfer immediately: no further requests and no done pulse.

Verification
REQ-034 base=0x1000, coords (0,0), tile 2x2, size 8x8, stride 32, elem_log2=2, req_ready=1 -> addrs 0x1000, 0x1004, 0x1020, 0x1024; smem +0, +4, +8, +12; last on 4th; done at cycle 7 after fire.
REQ-035 coords (-1,7), tile 2x2, size 8x8 -> oob pattern 1,0,1,1.
REQ-036 tile01 = 0x0003_0000 (tile0 = 0) -> zero requests; done_valid 3 cycles after fire.
REQ-037 req_ready toggling 1,0,0,1 during 2x1 tile -> outputs held stable while stalled; exactly 2 requests in order.
REQ-038 reset asserted mid-transfer after 1 of 4 requests -> req_valid drops asynchronously, no done; next transfer runs cleanly.
REQ-039 Back-to-back: second input presented in the done cycle -> accepted; done_tag = first tag; second transfer starts correctly.
